// File: rtl/arbiter_rr_n.sv
// arbiter_rr_n: N-channel round-robin arbiter, valid/ready on every channel, registered output with source ID.
// Define ARBITER_RR_N_LOCK_EN to hold the grant on one channel until its i_last beat (packet lock).
module arbiter_rr_n #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  localparam int ID_W  = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_CH-1:0]          i_valid,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  input  logic [N_CH-1:0]          i_last,
  output logic [N_CH-1:0]          o_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [ID_W-1:0]          o_id,
  output logic                     o_last,
  input  logic                     i_ready
);

  logic [ID_W-1:0]   ptr_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ID_W-1:0]   id_p1;
  logic              last_p1;

  logic [N_CH-1:0]   elig_p0;
  logic [N_CH-1:0]   gnt_p0;
  logic [ID_W-1:0]   gnt_id_p0;
  logic [DATA_W-1:0] gnt_data_p0;
  logic              gnt_last_p0;
  logic [ID_W-1:0]   cand_p0;
  logic              found_p0;
  logic              load_p0;
  logic              xfer_p0;

  // Wraps with an explicit compare so non-power-of-2 channel counts never alias through ID_W overflow.
  function automatic logic [ID_W-1:0] next_ch(input logic [ID_W-1:0] p, input int off);
    logic [ID_W:0] s;
    s = {1'b0, p} + (ID_W+1)'(off);
    if (s >= (ID_W+1)'(N_CH)) s = s - (ID_W+1)'(N_CH);
    return s[ID_W-1:0];
  endfunction

`ifdef ARBITER_RR_N_LOCK_EN
  logic            lock_p1;
  logic [ID_W-1:0] lock_ch_p1;

  always_comb begin
    elig_p0 = '0;
    if (lock_p1) elig_p0[lock_ch_p1] = i_valid[lock_ch_p1];
    else         elig_p0 = i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_p1    <= 1'b0;
      lock_ch_p1 <= '0;
    end else if (xfer_p0) begin
      lock_p1    <= !gnt_last_p0;
      lock_ch_p1 <= gnt_id_p0;
    end
  end
`else
  assign elig_p0 = i_valid;
`endif

  // Stage p0: round-robin search from ptr+1, grant and payload select
  always_comb begin
    gnt_p0      = '0;
    gnt_id_p0   = '0;
    gnt_data_p0 = '0;
    gnt_last_p0 = 1'b0;
    cand_p0     = '0;
    found_p0    = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      cand_p0 = next_ch(ptr_p1, i);
      if (!found_p0 && elig_p0[cand_p0]) begin
        found_p0         = 1'b1;
        gnt_p0[cand_p0]  = 1'b1;
        gnt_id_p0        = cand_p0;
        gnt_data_p0      = i_data[cand_p0*DATA_W +: DATA_W];
        gnt_last_p0      = i_last[cand_p0];
      end
    end
  end

  assign load_p0 = !vld_p1 || i_ready;
  // Reset gates o_ready so no beat is accepted upstream at an edge that discards it.
  assign o_ready = gnt_p0 & {N_CH{load_p0 && !i_reset}};
  assign xfer_p0 = |o_ready;

  // Stage p1: output register and grant pointer, both advance only on an accepted input beat
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
      ptr_p1  <= ID_W'(N_CH-1);
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= gnt_data_p0;
      id_p1   <= gnt_id_p0;
      last_p1 <= gnt_last_p0;
      ptr_p1  <= gnt_id_p0;
    end else if (i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_id    = id_p1;
  assign o_last  = last_p1;

endmodule
